// File: rtl/vector_control_sequencer.sv
// vector_control_sequencer
//   Multi-cycle opcode sequencer between instruction fetch and the
//   scalar/vector/histogram datapath. One 4-bit opcode is accepted per
//   valid/ready handshake. Scalar ops execute in one cycle. Vector and
//   histogram ops run NBEATS = LANES/GROUP beats, each enabling one lane group.
//   LOAD/STORE beats stall until mem_ready. CMP writes an internal Z flag,
//   and BNQ reads it.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   instr_valid/ready   opcode handshake; op is sampled on accept
//   zero_in             ALU zero result, captured by CMP
//   mem_ready           completes the current LOAD/STORE beat
//   pc_src .. get8      datapath strobes
//   alu_control         ALU operation (default 011)
//   lane_control        histogram lane operation (default 111)
//   lane_en, beat_idx   active lane group and beat number
//   busy, done, illegal status; done/illegal pulse in the completion cycle
module vector_control_sequencer #(
    parameter int LANES = 8,
    parameter int GROUP = 4,
    parameter int BW    = ((LANES / GROUP) > 1) ? $clog2(LANES / GROUP) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [3:0]       op,
    input  logic             zero_in,
    input  logic             mem_ready,
    output logic             pc_src,
    output logic             scalar_write,
    output logic             vector_write,
    output logic             histogram_write,
    output logic             mem_to_reg,
    output logic             mem_write,
    output logic             flag_write,
    output logic             imm_src,
    output logic             get8,
    output logic [2:0]       alu_control,
    output logic [2:0]       lane_control,
    output logic [LANES-1:0] lane_en,
    output logic [BW-1:0]    beat_idx,
    output logic             busy,
    output logic             done,
    output logic             illegal
);

    localparam int NBEATS = LANES / GROUP;

    generate
        if (LANES % GROUP != 0) begin : g_bad_group
            $error("LANES must be a multiple of GROUP");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t         state, state_nx;
    logic [3:0]     op_q;
    logic [BW-1:0]  beat, beat_nx;
    logic           z, z_nx;

    logic [LANES-1:0] grp_mask;
    logic [LANES-1:0] beat_mask;
    logic             beat_op;
    logic             mem_op;
    logic             advance;
    logic             last_beat;

    assign grp_mask  = LANES'({GROUP{1'b1}});
    assign beat_mask = grp_mask << (int'(beat) * GROUP);
    assign beat_op   = (op_q >= 4'd6) && (op_q <= 4'd12);
    assign mem_op    = (op_q == 4'd6) || (op_q == 4'd7);
    assign advance   = !mem_op || mem_ready;
    assign last_beat = (beat == BW'(NBEATS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            op_q  <= '0;
            beat  <= '0;
            z     <= 1'b0;
        end else begin
            state <= state_nx;
            beat  <= beat_nx;
            z     <= z_nx;
            if (state == IDLE && instr_valid)
                op_q <= op;
        end
    end

    always_comb begin
        state_nx        = state;
        beat_nx         = beat;
        z_nx            = z;
        instr_ready     = 1'b0;
        pc_src          = 1'b0;
        scalar_write    = 1'b0;
        vector_write    = 1'b0;
        histogram_write = 1'b0;
        mem_to_reg      = 1'b0;
        mem_write       = 1'b0;
        flag_write      = 1'b0;
        imm_src         = 1'b0;
        get8            = 1'b0;
        alu_control     = 3'b000;
        lane_control    = 3'b000;
        lane_en         = '0;
        beat_idx        = '0;
        busy            = 1'b0;
        done            = 1'b0;
        illegal         = 1'b0;

        // Outputs stay all-zero while reset is held, whatever the state.
        if (rst_n) begin
            alu_control  = 3'b011;
            lane_control = 3'b111;
            beat_idx     = beat;
            busy         = (state != IDLE);

            case (state)
                IDLE: begin
                    instr_ready = 1'b1;
                    if (instr_valid)
                        state_nx = EXEC;
                end
                EXEC: begin
                    if (beat_op) begin
                        lane_en = beat_mask;
                        if (advance) begin
                            if (last_beat) begin
                                beat_nx  = '0;
                                state_nx = DONE;
                            end else begin
                                beat_nx = beat + 1'b1;
                            end
                        end
                    end else begin
                        state_nx = DONE;
                    end

                    case (op_q)
                        4'd0: begin scalar_write = 1'b1; imm_src = 1'b1; alu_control = 3'b100; lane_en = '1; end
                        4'd1: begin scalar_write = 1'b1; alu_control = 3'b001; lane_en = '1; end
                        4'd2: begin scalar_write = 1'b1; imm_src = 1'b1; alu_control = 3'b000; lane_en = '1; end
                        4'd3: begin
                            flag_write  = 1'b1;
                            alu_control = 3'b010;
                            lane_en     = '1;
                            z_nx        = zero_in;
                        end
                        4'd4: begin pc_src = 1'b1; imm_src = 1'b1; lane_en = '1; end
                        4'd5: begin pc_src = ~z; imm_src = 1'b1; lane_en = '1; end
                        4'd6: begin mem_to_reg = 1'b1; vector_write = mem_ready; end
                        4'd7: mem_write = mem_ready;
                        4'd8: vector_write = 1'b1;
                        4'd9: begin histogram_write = 1'b1; lane_control = 3'b100; end
                        4'd10: begin histogram_write = 1'b1; lane_control = 3'b000; end
                        4'd11: begin histogram_write = 1'b1; lane_control = 3'b010; end
                        4'd12: begin vector_write = 1'b1; get8 = 1'b1; end
                        default: illegal = 1'b1;
                    endcase
                end
                DONE: begin
                    done     = 1'b1;
                    illegal  = (op_q >= 4'd13);
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_control_sequencer.sv
// Scoreboard bench for vector_control_sequencer. It uses two instances:
// dut0 has LANES=8 and GROUP=4 (2 beats), and dut1 has LANES=8 and GROUP=2
// (4 beats). The driver plans each instruction cycle by cycle. For every cycle
// it pushes the expected output bundle, computed from the opcode table. A
// negedge monitor pops each entry and compares it with the DUT's outputs.
module tb_vector_control_sequencer;

    localparam int LANES = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n[2], instr_valid[2], zero_in[2], mem_ready[2];
    logic [3:0] op[2];

    logic       instr_ready[2], pc_src[2], scalar_write[2], vector_write[2];
    logic       histogram_write[2], mem_to_reg[2], mem_write[2], flag_write[2];
    logic       imm_src[2], get8[2], busy[2], done[2], illegal[2];
    logic [2:0] alu_control[2], lane_control[2];
    logic [7:0] lane_en[2];
    logic [0:0] bi0;
    logic [1:0] bi1;

    vector_control_sequencer #(.LANES(8), .GROUP(4)) dut0 (
        .clk(clk), .rst_n(rst_n[0]), .instr_valid(instr_valid[0]), .instr_ready(instr_ready[0]),
        .op(op[0]), .zero_in(zero_in[0]), .mem_ready(mem_ready[0]), .pc_src(pc_src[0]),
        .scalar_write(scalar_write[0]), .vector_write(vector_write[0]),
        .histogram_write(histogram_write[0]), .mem_to_reg(mem_to_reg[0]),
        .mem_write(mem_write[0]), .flag_write(flag_write[0]), .imm_src(imm_src[0]),
        .get8(get8[0]), .alu_control(alu_control[0]), .lane_control(lane_control[0]),
        .lane_en(lane_en[0]), .beat_idx(bi0), .busy(busy[0]), .done(done[0]),
        .illegal(illegal[0])
    );

    vector_control_sequencer #(.LANES(8), .GROUP(2)) dut1 (
        .clk(clk), .rst_n(rst_n[1]), .instr_valid(instr_valid[1]), .instr_ready(instr_ready[1]),
        .op(op[1]), .zero_in(zero_in[1]), .mem_ready(mem_ready[1]), .pc_src(pc_src[1]),
        .scalar_write(scalar_write[1]), .vector_write(vector_write[1]),
        .histogram_write(histogram_write[1]), .mem_to_reg(mem_to_reg[1]),
        .mem_write(mem_write[1]), .flag_write(flag_write[1]), .imm_src(imm_src[1]),
        .get8(get8[1]), .alu_control(alu_control[1]), .lane_control(lane_control[1]),
        .lane_en(lane_en[1]), .beat_idx(bi1), .busy(busy[1]), .done(done[1]),
        .illegal(illegal[1])
    );

    // Bundle layout: {pc,sw,vw,hw,m2r,mw,fw,imm,g8, alu[3], lane[3], lane_en[8],
    //                 beat[2], busy, done, illegal, instr_ready}
    logic [28:0] obs0, obs1;
    assign obs0 = {pc_src[0], scalar_write[0], vector_write[0], histogram_write[0],
                   mem_to_reg[0], mem_write[0], flag_write[0], imm_src[0], get8[0],
                   alu_control[0], lane_control[0], lane_en[0], {1'b0, bi0},
                   busy[0], done[0], illegal[0], instr_ready[0]};
    assign obs1 = {pc_src[1], scalar_write[1], vector_write[1], histogram_write[1],
                   mem_to_reg[1], mem_write[1], flag_write[1], imm_src[1], get8[1],
                   alu_control[1], lane_control[1], lane_en[1], bi1,
                   busy[1], done[1], illegal[1], instr_ready[1]};

    localparam int S_PC = 8, S_SW = 7, S_VW = 6, S_HW = 5, S_M2R = 4;
    localparam int S_MW = 3, S_FW = 2, S_IMM = 1, S_G8 = 0;

    logic [28:0] q0[$], q1[$];
    logic        zm[2];           // reference Z flag per instance
    int          checks = 0;
    int          errors = 0;

    function automatic logic [28:0] mk(input logic [8:0] s, input logic [2:0] a,
                                       input logic [2:0] l, input logic [7:0] le,
                                       input logic [1:0] bt, input logic bz,
                                       input logic dn, input logic il, input logic rd);
        return {s, a, l, le, bt, bz, dn, il, rd};
    endfunction

    function automatic logic [28:0] exp_idle();
        return mk(9'd0, 3'b011, 3'b111, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endfunction

    function automatic logic [28:0] exp_done(input logic il);
        return mk(9'd0, 3'b011, 3'b111, 8'h00, 2'd0, 1'b1, 1'b1, il, 1'b0);
    endfunction

    function automatic logic [28:0] exp_exec(input int group, input logic [3:0] o,
                                             input logic z, input int beat,
                                             input logic mr);
        logic [8:0] s;
        logic [2:0] a, l;
        logic [7:0] le, mask;
        logic       il;
        s = '0; a = 3'b011; l = 3'b111; le = 8'h00; il = 1'b0;
        mask = 8'((1 << group) - 1);
        if (o >= 4'd6 && o <= 4'd12)
            le = mask << (beat * group);
        else if (o <= 4'd5)
            le = 8'hFF;
        case (o)
            4'd0: begin s[S_SW] = 1; s[S_IMM] = 1; a = 3'b100; end
            4'd1: begin s[S_SW] = 1; a = 3'b001; end
            4'd2: begin s[S_SW] = 1; s[S_IMM] = 1; a = 3'b000; end
            4'd3: begin s[S_FW] = 1; a = 3'b010; end
            4'd4: begin s[S_PC] = 1; s[S_IMM] = 1; end
            4'd5: begin s[S_PC] = ~z; s[S_IMM] = 1; end
            4'd6: begin s[S_M2R] = 1; s[S_VW] = mr; end
            4'd7: s[S_MW] = mr;
            4'd8: s[S_VW] = 1;
            4'd9: begin s[S_HW] = 1; l = 3'b100; end
            4'd10: begin s[S_HW] = 1; l = 3'b000; end
            4'd11: begin s[S_HW] = 1; l = 3'b010; end
            4'd12: begin s[S_VW] = 1; s[S_G8] = 1; end
            default: il = 1'b1;
        endcase
        return mk(s, a, l, le, 2'(beat), 1'b1, 1'b0, il, 1'b0);
    endfunction

    task automatic push(input int d, input logic [28:0] v);
        if (d == 0) q0.push_back(v);
        else        q1.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [28:0] e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            checks++;
            if (obs0 !== e) begin
                errors++;
                $display("FAIL dut0 outputs @%0t: got %h want %h", $time, obs0, e);
            end
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            checks++;
            if (obs1 !== e) begin
                errors++;
                $display("FAIL dut1 outputs @%0t: got %h want %h", $time, obs1, e);
            end
        end
    end

    task automatic do_reset(input int d);
        rst_n[d] = 1'b0; instr_valid[d] = 1'b1; op[d] = 4'($urandom);
        for (int i = 0; i < 2; i++) begin
            push(d, 29'd0);
            step();
        end
        zm[d] = 1'b0;
        rst_n[d] = 1'b1; instr_valid[d] = 1'b0;
        push(d, exp_idle());
        step();
    endtask

    // zsel: -1 random zero_in, else forced value. stall0: -1 random stalls on
    // every memory beat, else that many stalls on beat 0 and none afterwards.
    task automatic run_op(input int d, input logic [3:0] o, input int zsel, input int stall0);
        int   group, nb, s;
        logic zin, mr;
        group = (d == 0) ? 4 : 2;
        nb    = LANES / group;
        instr_valid[d] = 1'b1; op[d] = o;
        push(d, exp_idle());
        step();
        instr_valid[d] = 1'($urandom_range(0, 1));
        op[d] = 4'($urandom);
        if (o <= 4'd5 || o >= 4'd13) begin
            zin = (zsel < 0) ? 1'($urandom_range(0, 1)) : zsel[0];
            zero_in[d] = zin;
            mem_ready[d] = 1'($urandom_range(0, 1));
            push(d, exp_exec(group, o, zm[d], 0, 1'b0));
            if (o == 4'd3) zm[d] = zin;
            step();
        end else begin
            for (int b = 0; b < nb; b++) begin
                if (o == 4'd6 || o == 4'd7)
                    s = (stall0 < 0) ? $urandom_range(0, 3) : ((b == 0) ? stall0 : 0);
                else
                    s = 0;
                for (int k = 0; k <= s; k++) begin
                    if (o == 4'd6 || o == 4'd7) mr = (k == s);
                    else                        mr = 1'($urandom_range(0, 1));
                    mem_ready[d] = mr;
                    zero_in[d] = 1'($urandom_range(0, 1));
                    push(d, exp_exec(group, o, zm[d], b, mr));
                    step();
                end
            end
        end
        instr_valid[d] = 1'b0;
        zero_in[d] = 1'($urandom_range(0, 1));
        mem_ready[d] = 1'($urandom_range(0, 1));
        push(d, exp_done(o >= 4'd13));
        step();
    endtask

    // MODS aborted by reset during its second beat.
    task automatic abort_mods(input int d);
        int group;
        group = (d == 0) ? 4 : 2;
        instr_valid[d] = 1'b1; op[d] = 4'd8;
        push(d, exp_idle());
        step();
        instr_valid[d] = 1'b0;
        push(d, exp_exec(group, 4'd8, zm[d], 0, 1'b1));
        step();
        rst_n[d] = 1'b0;
        push(d, 29'd0);
        step();
        rst_n[d] = 1'b1;
        zm[d] = 1'b0;
        push(d, exp_idle());
        step();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; instr_valid[d] = 1'b0; op[d] = '0;
            zero_in[d] = 1'b0; mem_ready[d] = 1'b0; zm[d] = 1'b0;
        end
        step();

        do_reset(0);
        run_op(0, 4'd2, -1, -1);      // ADD
        run_op(0, 4'd3, 1, -1);       // CMP, Z=1
        run_op(0, 4'd5, -1, -1);      // BNQ -> pc_src=0
        run_op(0, 4'd3, 0, -1);       // CMP, Z=0
        run_op(0, 4'd5, -1, -1);      // BNQ -> pc_src=1
        run_op(0, 4'd4, -1, -1);      // B
        run_op(0, 4'd6, -1, 2);       // LOAD with two stalls on beat 0
        run_op(0, 4'd15, -1, -1);     // illegal
        run_op(0, 4'd7, -1, -1);      // STORE, random stalls
        for (int i = 0; i < 40; i++)
            run_op(0, 4'($urandom_range(0, 15)), -1, -1);

        do_reset(1);
        run_op(1, 4'd11, -1, -1);     // MULS over 4 beats
        run_op(1, 4'd3, 1, -1);       // CMP, Z=1
        abort_mods(1);                // reset clears Z
        run_op(1, 4'd5, -1, -1);      // BNQ -> pc_src=1
        for (int i = 0; i < 40; i++)
            run_op(1, 4'($urandom_range(0, 15)), -1, -1);

        step();
        step();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: left %0d/%0d want 0/0", q0.size(), q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
